// File: rtl/nn_pkg.sv
// Shared types and constants for the XOR network result path: float helpers,
// exception-bit positions and the buffered result entry.
package nn_pkg;
    localparam int FLOAT_W = 32;
    localparam int EXP_W   = 8;
    localparam int EXC_W   = 5;
    localparam logic [FLOAT_W-1:0] FLOAT_HALF = 32'h3F00_0000;

    localparam int EXC_INVALID   = 4;
    localparam int EXC_DIV0      = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    typedef struct packed {
        logic [FLOAT_W-1:0] data;
        logic [EXC_W-1:0]   exc;
        logic               cbit;
        logic               exp;
        logic               err;
    } result_entry_t;

    function automatic logic is_nan(input logic [FLOAT_W-1:0] f);
        return (&f[FLOAT_W-2 -: EXP_W]) && (|f[FLOAT_W-2-EXP_W:0]);
    endfunction
endpackage

// File: rtl/nn_result_fifo.sv
// Synchronous FIFO of result entries; head is read from storage registers,
// so a written entry becomes visible one cycle after the push.
module nn_result_fifo import nn_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  result_entry_t wdata,
    output result_entry_t rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    result_entry_t   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & (~full | do_pop) & ~clr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Storage is not reset; mask the head so outputs read 0 while empty.
    assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/nn_xor_result_collector.sv
// Tracks issued A/B pairs through the network latency, classifies the float
// output at capture time, buffers results and keeps pass/error statistics.
module nn_xor_result_collector import nn_pkg::*; #(
    parameter  int exp_width  = 8,
    parameter  int mant_width = 24,
    parameter  int NN_LATENCY = 3,
    parameter  int DEPTH      = 4,
    parameter  logic [exp_width+mant_width-1:0] THRESH = FLOAT_HALF,
    parameter  int CNT_W      = 16,
    localparam int W          = exp_width + mant_width
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             issue,
    input  logic             in_a_bit,
    input  logic             in_b_bit,
    input  logic [W-1:0]     nn_out,
    input  logic [4:0]       nn_exc,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [4:0]       out_exc,
    output logic             out_bit,
    output logic             out_exp,
    output logic             out_err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    output logic [4:0]       exc_sticky
);
    localparam int AW = $clog2(DEPTH);

    logic [NN_LATENCY-1:0] tag_v, tag_a, tag_b;
    logic                  cap, live, pop, push, drop;
    logic                  nan, res_bit, exp_bit, err_bit;
    logic                  full, empty;
    logic [AW:0]           occ;
    result_entry_t         entry, head;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tag_v <= '0;
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_a[0] <= in_a_bit;
            tag_b[0] <= in_b_bit;
            for (int i = 1; i < NN_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    assign cap     = tag_v[NN_LATENCY-1];
    assign nan     = is_nan(nn_out);
    // Sign-magnitude compare on the non-sign bits orders all positive floats, Inf included.
    assign res_bit = ~nn_out[W-1] & ~nan & (nn_out[W-2:0] >= THRESH[W-2:0]);
    assign exp_bit = tag_a[NN_LATENCY-1] ^ tag_b[NN_LATENCY-1];
    assign err_bit = nan | (res_bit ^ exp_bit);

    assign live = cap & ~clr;
    assign pop  = out_valid & out_ready;
    assign push = live & (~full | pop);
    assign drop = live & full & ~pop;

    assign entry = '{data: nn_out, exc: nn_exc, cbit: res_bit, exp: exp_bit, err: err_bit};

    nn_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    always_comb assert (empty == (occ == '0));

    assign out_valid = ~empty;
    assign out_data  = head.data;
    assign out_exc   = head.exc;
    assign out_bit   = head.cbit;
    assign out_exp   = head.exp;
    assign out_err   = head.err;

    // Statistics count every live capture, including ones the FIFO had to drop.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pass_cnt   <= '0;
            err_cnt    <= '0;
            overflow   <= 1'b0;
            exc_sticky <= '0;
        end else if (clr) begin
            pass_cnt   <= '0;
            err_cnt    <= '0;
            overflow   <= 1'b0;
            exc_sticky <= '0;
        end else if (live) begin
            exc_sticky <= exc_sticky | nn_exc;
            if (drop) overflow <= 1'b1;
            if (err_bit) begin
                if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            end else begin
                if (!(&pass_cnt)) pass_cnt <= pass_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/nn_xor_result_collector.md
Name: nn_xor_result_collector

Overview:
- Downstream stage of the 2-2-1 XOR network datapath. It tracks each issued input pair through the network's fixed latency and samples the network's float output and exception flags at the correct cycle.
- Each sample is classified against a float threshold, checked against the expected XOR, and buffered in a small FIFO with a valid/ready drain port.
- Saturating pass/error counters and sticky flags are kept for the test harness or host.

Parameters:
- exp_width, 8, float exponent width
- mant_width, 24, float sign+mantissa width; word width W = exp_width+mant_width
- NN_LATENCY, 3, cycles from issue to a valid nn_out (>=1)
- DEPTH, 4, result FIFO entries, power of 2, >=2
- THRESH, 32'h3F00_0000, classification threshold (+0.5)
- CNT_W, 16, counter width

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- issue  in  1  one-cycle pulse: a new A/B pair was applied to the network this cycle
- in_a_bit  in  1  logical value of A for this issue
- in_b_bit  in  1  logical value of B for this issue
- nn_out  in  W  network float output (XOR_output)
- nn_exc  in  5  network exception flags
- clr  in  1  synchronous clear of FIFO, counters and sticky flags
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  W  raw float of head entry
- out_exc  out  5  exceptions of head entry
- out_bit  out  1  classified result of head entry
- out_exp  out  1  expected XOR (a^b) of head entry
- out_err  out  1  head entry mismatched or NaN
- pass_cnt  out  CNT_W  saturating count of correct results
- err_cnt  out  CNT_W  saturating count of errors
- overflow  out  1  sticky: a capture was dropped because the FIFO was full
- exc_sticky  out  5  OR of all captured nn_exc

Behaviour:
- Reset (rst_l=0, async): all outputs 0, FIFO empty, tag pipeline cleared. Reset in mid-operation discards all in-flight tags.
- Tag pipeline: NN_LATENCY-stage shift register of {valid, a, b}. Stage 0 loads {issue, in_a_bit, in_b_bit} every cycle. Issues are allowed every cycle; each is tracked independently.
- Capture: in the cycle when the tag leaves the last stage (issue at cycle t means capture at t+NN_LATENCY), nn_out and nn_exc are sampled combinationally that cycle.
- Classify:
  - NaN = exponent all ones and fraction nonzero.
  - bit = 1 iff sign=0, not NaN, and nn_out[W-2:0] >= THRESH[W-2:0] (unsigned magnitude compare).
  - +Inf gives 1. Any negative value or -0 gives 0.
  - err = NaN | (bit != a^b).
- Push: the entry {nn_out, nn_exc, bit, a^b, err} is written if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the entry is dropped and overflow is set. Counters and exc_sticky still update on a dropped entry.
- Counters: err=1 increments err_cnt, else pass_cnt increments. Both saturate at all ones. exc_sticky |= nn_exc on each capture.
- Pop: occurs when out_valid & out_ready. out_valid=1 iff occupancy>0. Head fields are registered/FIFO-read with no fall-through, so the first out_valid rises at t+NN_LATENCY+1.
- Simultaneous push+pop on an empty FIFO is not possible (out_valid=0). On a non-empty FIFO, occupancy is unchanged.
- Pointers: log2(DEPTH) bits with wrap-around. Occupancy is held in a separate log2(DEPTH)+1 bit counter.
- clr: next cycle FIFO is empty, counters are 0, overflow and exc_sticky are 0. The tag pipeline is not flushed. A capture coinciding with clr is discarded and not counted.
- Handshake: out_data and the other head fields hold stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package nn_pkg holds:
  - FLOAT_HALF constant (32'h3F00_0000)
  - the exception-bit index localparams (invalid, div0, overflow, underflow, inexact)
  - typedef result_entry_t {data, exc, bit, exp, err}
  - function is_nan()
- One sub-module, nn_result_fifo: a parameterised synchronous FIFO of result_entry_t with push/pop/full/empty/count. The collector instantiates it and owns the tag pipeline, classification, counters and flags.

Test Plan:
- Reset then idle: after rst_l release, all outputs are 0 and out_valid stays 0 for 20 cycles with issue=0.
- Single correct issue at cycle 10 with a=1, b=0 and nn_out=32'h3F66_6666 (0.9) presented at cycle 13: out_valid rises at cycle 14 with out_bit=1, out_exp=1, out_err=0, and pass_cnt=1.
- Mismatch and NaN:
  - a=1, b=1 with nn_out=32'h3F40_0000 (0.75) gives err=1.
  - A following nn_out=32'h7FC0_0000 gives out_bit=0 and err=1.
  - Result: err_cnt=2, pass_cnt=0.
- Back-to-back issues: 4 consecutive issues with out_ready=0 fill the FIFO. A 5th issue sets overflow=1 with occupancy still 4 and err_cnt+pass_cnt=5. The FIFO then drains in order with out_ready=1.
- Full with simultaneous pop: with the FIFO full and out_ready=1 on the cycle a capture arrives, the entry is accepted, overflow stays 0 and occupancy stays 4.
- Reset and clear:
  - Assert rst_l=0 asynchronously mid-stream with 2 tags in flight and 3 entries buffered: all state goes to 0 immediately and no output appears after release.
  - clr with exc_sticky=5'b00001 clears it to 0 on the next cycle.
